rvm_shift_iter: RTL and testbench

//  Multi-cycle, parametrised shifter/rotator for the multi-cycle core datapath.

---
 rtl/rvm_shift_iter_pkg.sv | 27 ++
 rtl/rvm_shift_step.sv | 39 +++
 rtl/rvm_shift_iter.sv | 107 ++++++++++
 tb/tb_rvm_shift_iter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvm_shift_iter_pkg.sv
// Shared opcodes and FSM states for the iterative shifter/rotator.
// Included by rvm_shift_step and rvm_shift_iter.
package rvm_shift_iter_pkg;

  localparam logic [2:0] RVM_SHIFT_NOP = 3'b000;
  localparam logic [2:0] RVM_SHIFT_SLL = 3'b001;
  localparam logic [2:0] RVM_SHIFT_SRL = 3'b010;
  localparam logic [2:0] RVM_SHIFT_SRA = 3'b011;
  localparam logic [2:0] RVM_SHIFT_ROL = 3'b100;
  localparam logic [2:0] RVM_SHIFT_ROR = 3'b101;

  typedef enum logic [1:0] {
    RVM_SHIFT_ITER_IDLE = 2'b00,
    RVM_SHIFT_ITER_BUSY = 2'b01,
    RVM_SHIFT_ITER_DONE = 2'b10
  } rvm_shift_iter_state_e;

  typedef struct packed {
    logic [2:0] op;
    logic       sign;
  } rvm_shift_ctl_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op >= RVM_SHIFT_SLL) && (op <= RVM_SHIFT_ROR);
  endfunction

endpackage

// File: rtl/rvm_shift_step.sv
// One combinational shift/rotate step of up to STEP bit positions.
// Reserved/NOP opcodes pass the accumulator through.
module rvm_shift_step
  import rvm_shift_iter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic [XLEN-1:0]          acc,
  input  logic [$clog2(STEP):0]    n,
  input  logic [2:0]               op,
  input  logic                     sign,
  output logic [XLEN-1:0]          acc_next
);

  localparam int AW = $clog2(XLEN) + 1;

  logic [AW-1:0] amt;
  logic [AW-1:0] inv;

  assign amt = AW'(n);
  assign inv = AW'(XLEN) - amt;

  always_comb begin
    acc_next = acc;
    unique case (1'b1)
      (op == RVM_SHIFT_SLL): acc_next = acc << amt;
      (op == RVM_SHIFT_SRL): acc_next = acc >> amt;
      (op == RVM_SHIFT_SRA):
        acc_next = XLEN'($signed({sign, acc}) >>> amt);
      (op == RVM_SHIFT_ROL):
        acc_next = (acc << amt) | (acc >> inv);
      (op == RVM_SHIFT_ROR):
        acc_next = (acc >> amt) | (acc << inv);
      default: acc_next = acc;
    endcase
  end

endmodule

// File: rtl/rvm_shift_iter.sv
// Multi-cycle shifter/rotator: STEP positions per clock,
// valid/ready request and response handshakes.
module rvm_shift_iter
  import rvm_shift_iter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 4,
  localparam int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [XLEN-1:0]    req_lhs,
  input  logic [SHAMT_W-1:0] req_rhs,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [XLEN-1:0]    rsp_result
);

  localparam int NW = $clog2(STEP) + 1;
  localparam int RW = SHAMT_W + 1;

  rvm_shift_iter_state_e state_q, state_d;
  logic [XLEN-1:0]    acc_q, acc_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  rvm_shift_ctl_t     ctl_q, ctl_d;

  logic [NW-1:0]   n_step;
  logic [XLEN-1:0] acc_step;

  // Clamp this cycle's distance to what the step network can do.
  always_comb begin
    if ({1'b0, rem_q} >= RW'(STEP))
      n_step = NW'(STEP);
    else
      n_step = NW'(rem_q);
  end

  rvm_shift_step #(
    .XLEN(XLEN),
    .STEP(STEP)
  ) u_step (
    .acc      (acc_q),
    .n        (n_step),
    .op       (ctl_q.op),
    .sign     (ctl_q.sign),
    .acc_next (acc_step)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RVM_SHIFT_ITER_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      ctl_q   <= '{op: RVM_SHIFT_NOP, sign: 1'b0};
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      ctl_q   <= ctl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    ctl_d   = ctl_q;
    if (flush) begin
      state_d = RVM_SHIFT_ITER_IDLE;
    end else begin
      unique case (state_q)
        RVM_SHIFT_ITER_IDLE: begin
          if (req_valid) begin
            acc_d      = is_shift(req_op) ? req_lhs : '0;
            rem_d      = req_rhs;
            ctl_d.op   = req_op;
            ctl_d.sign = req_lhs[XLEN-1];
            if (is_shift(req_op) && (req_rhs != '0))
              state_d = RVM_SHIFT_ITER_BUSY;
            else
              state_d = RVM_SHIFT_ITER_DONE;
          end
        end
        RVM_SHIFT_ITER_BUSY: begin
          acc_d = acc_step;
          rem_d = rem_q - SHAMT_W'(n_step);
          if (rem_d == '0)
            state_d = RVM_SHIFT_ITER_DONE;
        end
        RVM_SHIFT_ITER_DONE: begin
          if (rsp_ready)
            state_d = RVM_SHIFT_ITER_IDLE;
        end
        default: state_d = RVM_SHIFT_ITER_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == RVM_SHIFT_ITER_IDLE);
  assign rsp_valid  = (state_q == RVM_SHIFT_ITER_DONE);
  assign rsp_result = rsp_valid ? acc_q : '0;

endmodule

// File: tb/tb_rvm_shift_iter.sv
// Randomized and directed checks of rvm_shift_iter
// against a behavioural shift/rotate model.
module tb_rvm_shift_iter;

  localparam int XLEN = 32;
  localparam int STEP = 4;
  localparam int MAXLAT = 40;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_lhs;
  logic [4:0]  req_rhs;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;

  int n_cmp = 0;
  int n_err = 0;

  rvm_shift_iter #(
    .XLEN(XLEN),
    .STEP(STEP)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_lhs    (req_lhs),
    .req_rhs    (req_rhs),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_res(
    input logic [2:0] op, input logic [31:0] a, input int s);
    logic [63:0] d;
    d = {a, a};
    case (op)
      3'd1: return a << s;
      3'd2: return a >> s;
      3'd3: return $unsigned($signed(a) >>> s);
      3'd4: begin d = d << s; return d[63:32]; end
      3'd5: begin d = d >> s; return d[31:0]; end
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input int s);
    if (op == 3'd0 || op > 3'd5 || s == 0) return 1;
    return (s + STEP - 1) / STEP + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, check latency/result, let it be consumed.
  task automatic run_op(input logic [2:0] op, input logic [31:0] lhs,
                        input int s, input string name);
    logic [31:0] exp_res;
    int exp_lat;
    int lat;
    bit seen;
    exp_res = ref_res(op, lhs, s);
    exp_lat = ref_lat(op, s);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1;
    req_op = op;
    req_lhs = lhs;
    req_rhs = 5'(s);
    tick();
    req_valid = 1'b0;
    req_op = 3'($urandom);
    req_lhs = $urandom;
    req_rhs = 5'($urandom);
    lat = 1;
    seen = 0;
    while (!seen && lat <= MAXLAT) begin
      if (rsp_valid === 1'b1) seen = 1;
      else begin tick(); lat++; end
    end
    n_cmp++;
    if (!seen || lat != exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_cmp++;
    if (rsp_result !== exp_res) begin
      n_err++;
      $display("FAIL %s result: got %h want %h", name, rsp_result, exp_res);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'h0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s consume: got v=%b r=%h rdy=%b want 0/0/1",
               name, rsp_valid, rsp_result, req_ready);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'h0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset: got v=%b r=%h rdy=%b want 0/0/1",
               rsp_valid, rsp_result, req_ready);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    run_op(3'd1, 32'h0000_0001, 31, "sll31");
    run_op(3'd3, 32'h8000_0000, 4, "sra4");
    run_op(3'd2, 32'h8000_0000, 4, "srl4");
    run_op(3'd5, 32'h0000_00F1, 4, "ror4");
    run_op(3'd4, 32'h8000_0001, 1, "rol1");
    for (int op = 0; op < 8; op++)
      run_op(3'(op), 32'hDEAD_BEEF, 0, "shamt0");
    run_op(3'd0, 32'hDEAD_BEEF, 7, "nop7");
    run_op(3'd7, 32'hDEAD_BEEF, 13, "rsv13");
    run_op(3'd3, 32'h7FFF_FFFF, 31, "sra_pos31");
    run_op(3'd5, 32'h1234_5678, 31, "ror31");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++)
      run_op(3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 31), "rand");
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_res;
    exp_res = ref_res(3'd2, 32'hA5A5_0000, 9);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_op = 3'd2;
    req_lhs = 32'hA5A5_0000;
    req_rhs = 5'd9;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < MAXLAT && rsp_valid !== 1'b1; i++) tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_result !== exp_res || req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold: got v=%b r=%h rdy=%b want 1/%h/0",
                 rsp_valid, rsp_result, req_ready, exp_res);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release: got rdy=%b v=%b want 1/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_flush();
    bit bad;
    req_valid = 1'b1;
    req_op = 3'd1;
    req_lhs = $urandom;
    req_rhs = 5'd20;
    tick();
    req_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid !== 1'b0) bad = 1;
      tick();
    end
    n_cmp++;
    if (bad || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_busy: got stray=%b rdy=%b want 0/1", bad, req_ready);
    end
    // flush beats a same-cycle accept
    flush = 1'b1;
    req_valid = 1'b1;
    req_op = 3'd0;
    req_rhs = 5'd0;
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_accept: got v=%b rdy=%b want 0/1", rsp_valid, req_ready);
    end
    // flush discards an unconsumed result
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_op = 3'd4;
    req_lhs = 32'h1;
    req_rhs = 5'd0;
    tick();
    req_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    rsp_ready = 1'b1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'h0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_done: got v=%b r=%h rdy=%b want 0/0/1",
               rsp_valid, rsp_result, req_ready);
    end
    run_op(3'd2, 32'h0000_00F0, 4, "post_flush");
  endtask

  task automatic test_reset_midop();
    req_valid = 1'b1;
    req_op = 3'd5;
    req_lhs = $urandom;
    req_rhs = 5'd30;
    tick();
    req_valid = 1'b0;
    tick();
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_result !== 32'h0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_midop: got v=%b r=%h rdy=%b want 0/0/1",
               rsp_valid, rsp_result, req_ready);
    end
    tick();
    resetn = 1'b1;
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_residual: got v=%b want 0", rsp_valid);
    end
    run_op(3'd3, 32'hF000_000F, 6, "post_reset");
  endtask

  initial begin
    resetn = 1'b0;
    flush = 1'b0;
    req_valid = 1'b0;
    req_op = 3'd0;
    req_lhs = 32'h0;
    req_rhs = 5'd0;
    rsp_ready = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_reset_midop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
